// File: rtl/conv2d_engine.sv
// conv2d_engine: single-channel 2D convolution (valid padding, stride 1).
// Streams a K x K window per output from sync-read image/weight memories,
// one MAC per cycle, then bias + round + optional ReLU + saturate, and
// writes each result to the result memory in raster order.
module conv2d_engine #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 3,
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 8,
    parameter int BIAS_W  = 16,
    parameter int ACC_W   = 32,
    parameter int SHIFT   = 8,
    parameter int OUT_W   = 8,
    parameter int RELU_EN = 1,
    parameter int IA_W    = 10,
    parameter int WA_W    = 4,
    parameter int OA_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BIAS_W-1:0] bias,
    output logic [IA_W-1:0]   img_addr,
    input  logic [DATA_W-1:0] img_data,
    output logic [WA_W-1:0]   w_addr,
    input  logic [COEF_W-1:0] w_data,
    output logic              out_wen,
    output logic [OA_W-1:0]   out_addr,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy,
    output logic              done
);

    localparam int OH     = IMG_H - K + 1;
    localparam int OW     = IMG_W - K + 1;
    localparam int MAXD   = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW     = $clog2(MAXD + 1);
    localparam int PROD_W = DATA_W + COEF_W + 1;

    // Rounding constant is half an LSB of the shifted result (zero when SHIFT=0).
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'((64'd1 << SHIFT) >> 1);
    localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_QUANT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0] r_reg, c_reg;
    logic [CW-1:0] kr_reg, kc_reg;
    logic [CW-1:0] kr_step, kc_step;
    logic [CW-1:0] r_step, c_step;
    logic signed [ACC_W-1:0] acc_reg;
    logic [IA_W-1:0]  img_addr_reg;
    logic [WA_W-1:0]  w_addr_reg;
    logic [OA_W-1:0]  out_addr_reg;
    logic [OUT_W-1:0] out_data_reg;

    logic first_tap, last_tap, last_out;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [ACC_W-1:0]  q_shift;
    logic signed [ACC_W-1:0]  q_clip;
    logic [OUT_W-1:0]         q_sat;

    assign img_addr = img_addr_reg;
    assign w_addr   = w_addr_reg;
    assign out_addr = out_addr_reg;
    assign out_data = out_data_reg;

    // Linear image address of window origin (rr,cc) plus tap offset (kkr,kkc).
    function automatic logic [IA_W-1:0] tap_addr(input logic [CW-1:0] rr,
                                                 input logic [CW-1:0] cc,
                                                 input logic [CW-1:0] kkr,
                                                 input logic [CW-1:0] kkc);
        return (IA_W'(rr) + IA_W'(kkr)) * IA_W'(IMG_W) + IA_W'(cc) + IA_W'(kkc);
    endfunction

    assign first_tap = (kr_reg == '0) && (kc_reg == '0);
    assign last_tap  = (kr_reg == CW'(K - 1)) && (kc_reg == CW'(K - 1));
    assign last_out  = (r_reg == CW'(OH - 1)) && (c_reg == CW'(OW - 1));

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod     = PROD_W'($signed({1'b0, img_data})) * PROD_W'($signed(w_data));
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias};

    // Row-major tap stepping and raster output stepping.
    always_comb begin
        kc_step = kc_reg + CW'(1);
        kr_step = kr_reg;
        if (kc_reg == CW'(K - 1)) begin
            kc_step = '0;
            kr_step = kr_reg + CW'(1);
        end
        c_step = c_reg + CW'(1);
        r_step = r_reg;
        if (c_reg == CW'(OW - 1)) begin
            c_step = '0;
            r_step = r_reg + CW'(1);
        end
    end

    // Requantisation: round half up, arithmetic shift, optional ReLU, saturate.
    always_comb begin
        rnd_sum = acc_reg + RND;
        q_shift = rnd_sum >>> SHIFT;
        q_clip  = q_shift;
        if ((RELU_EN != 0) && (q_shift < 0)) begin
            q_clip = '0;
        end
        if (q_clip > OMAX) begin
            q_sat = OMAX[OUT_W-1:0];
        end else if (q_clip < OMIN) begin
            q_sat = OMIN[OUT_W-1:0];
        end else begin
            q_sat = q_clip[OUT_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_MAC;
            S_MAC:   if (last_tap) state_next = S_DRAIN;
            S_DRAIN: state_next = S_QUANT;
            S_QUANT: state_next = S_WRITE;
            S_WRITE: state_next = last_out ? S_DONE : S_MAC;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status and strobe outputs decode straight from the state so reset clears them at once.
    always_comb begin
        busy    = (state_reg != S_IDLE);
        out_wen = (state_reg == S_WRITE);
        done    = (state_reg == S_DONE);
    end

    // Datapath: window/tap counters, memory addresses, accumulator, result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg        <= '0;
            c_reg        <= '0;
            kr_reg       <= '0;
            kc_reg       <= '0;
            acc_reg      <= '0;
            img_addr_reg <= '0;
            w_addr_reg   <= '0;
            out_addr_reg <= '0;
            out_data_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        r_reg        <= '0;
                        c_reg        <= '0;
                        kr_reg       <= '0;
                        kc_reg       <= '0;
                        acc_reg      <= bias_ext;
                        img_addr_reg <= '0;
                        w_addr_reg   <= '0;
                    end
                end
                S_MAC: begin
                    // Memory data lags the address by one cycle, so the first
                    // MAC cycle has nothing to accumulate yet.
                    if (!first_tap) begin
                        acc_reg <= acc_reg + prod_ext;
                    end
                    if (!last_tap) begin
                        kr_reg       <= kr_step;
                        kc_reg       <= kc_step;
                        img_addr_reg <= tap_addr(r_reg, c_reg, kr_step, kc_step);
                        w_addr_reg   <= WA_W'(kr_step) * WA_W'(K) + WA_W'(kc_step);
                    end
                end
                S_DRAIN: begin
                    acc_reg <= acc_reg + prod_ext;
                end
                S_QUANT: begin
                    out_data_reg <= q_sat;
                    out_addr_reg <= OA_W'(r_reg) * OA_W'(OW) + OA_W'(c_reg);
                end
                S_WRITE: begin
                    r_reg <= r_step;
                    c_reg <= c_step;
                    if (!last_out) begin
                        acc_reg      <= bias_ext;
                        kr_reg       <= '0;
                        kc_reg       <= '0;
                        img_addr_reg <= tap_addr(r_step, c_step, '0, '0);
                        w_addr_reg   <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_engine.sv
// tb_conv2d_engine: directed checks of conv2d_engine across five parameter sets
// (4x4/K2, 5x5/K3 with and without ReLU, SHIFT=8 rounding, 5x3 address walk).
module tb_conv2d_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  start_v;
    logic [15:0] bias_v     [5];
    logic [9:0]  img_addr_v [5];
    logic [7:0]  img_data_v [5];
    logic [3:0]  w_addr_v   [5];
    logic [7:0]  w_data_v   [5];
    logic [4:0]  wen_v, busy_v, done_v;
    logic [9:0]  oaddr_v    [5];
    logic [7:0]  odata_v    [5];

    logic [7:0] img_mem [5][1024];
    logic [7:0] w_mem   [5][16];

    int checks   = 0;
    int failures = 0;

    int wr_addr_q [5][$];
    int wr_data_q [5][$];
    int done_cnt  [5];
    int mac_img_q [$];
    int mac_w_q   [$];

    // A: 4x4 K=2 SHIFT=0 ReLU
    conv2d_engine #(.IMG_W(4), .IMG_H(4), .K(2), .SHIFT(0), .RELU_EN(1)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .bias(bias_v[0]),
        .img_addr(img_addr_v[0]), .img_data(img_data_v[0]),
        .w_addr(w_addr_v[0]), .w_data(w_data_v[0]),
        .out_wen(wen_v[0]), .out_addr(oaddr_v[0]), .out_data(odata_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));

    // B: 5x5 K=3 SHIFT=0 ReLU
    conv2d_engine #(.IMG_W(5), .IMG_H(5), .K(3), .SHIFT(0), .RELU_EN(1)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .bias(bias_v[1]),
        .img_addr(img_addr_v[1]), .img_data(img_data_v[1]),
        .w_addr(w_addr_v[1]), .w_data(w_data_v[1]),
        .out_wen(wen_v[1]), .out_addr(oaddr_v[1]), .out_data(odata_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));

    // C: 5x5 K=3 SHIFT=0 no ReLU
    conv2d_engine #(.IMG_W(5), .IMG_H(5), .K(3), .SHIFT(0), .RELU_EN(0)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .bias(bias_v[2]),
        .img_addr(img_addr_v[2]), .img_data(img_data_v[2]),
        .w_addr(w_addr_v[2]), .w_data(w_data_v[2]),
        .out_wen(wen_v[2]), .out_addr(oaddr_v[2]), .out_data(odata_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));

    // D: 3x3 K=2 SHIFT=8 no ReLU
    conv2d_engine #(.IMG_W(3), .IMG_H(3), .K(2), .SHIFT(8), .RELU_EN(0)) u_d (
        .clk(clk), .rst(rst), .start(start_v[3]), .bias(bias_v[3]),
        .img_addr(img_addr_v[3]), .img_data(img_data_v[3]),
        .w_addr(w_addr_v[3]), .w_data(w_data_v[3]),
        .out_wen(wen_v[3]), .out_addr(oaddr_v[3]), .out_data(odata_v[3]),
        .busy(busy_v[3]), .done(done_v[3]));

    // E: 5 wide x 3 high K=2 SHIFT=0 ReLU
    conv2d_engine #(.IMG_W(5), .IMG_H(3), .K(2), .SHIFT(0), .RELU_EN(1)) u_e (
        .clk(clk), .rst(rst), .start(start_v[4]), .bias(bias_v[4]),
        .img_addr(img_addr_v[4]), .img_data(img_data_v[4]),
        .w_addr(w_addr_v[4]), .w_data(w_data_v[4]),
        .out_wen(wen_v[4]), .out_addr(oaddr_v[4]), .out_data(odata_v[4]),
        .busy(busy_v[4]), .done(done_v[4]));

    // Sync-read memory models: data one cycle after address.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            img_data_v[i] <= img_mem[i][img_addr_v[i]];
            w_data_v[i]   <= w_mem[i][w_addr_v[i]];
        end
    end

    // Transaction monitor: log writes, count done pulses, trace E's addresses.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (wen_v[i] === 1'b1) begin
                wr_addr_q[i].push_back(int'(oaddr_v[i]));
                wr_data_q[i].push_back(int'($signed(odata_v[i])));
                $display("wr inst=%0d addr=%0d data=%0d", i, oaddr_v[i], $signed(odata_v[i]));
            end
            if (done_v[i] === 1'b1) begin
                done_cnt[i]++;
            end
        end
        if (busy_v[4] === 1'b1) begin
            mac_img_q.push_back(int'(img_addr_v[4]));
            mac_w_q.push_back(int'(w_addr_v[4]));
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle (cycle 0) and wait for done; done_cyc=-1 on timeout.
    task automatic run(input int idx, input int budget, output int done_cyc);
        wr_addr_q[idx].delete();
        wr_data_q[idx].delete();
        done_cyc = -1;
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (done_v[idx] === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // Every output of a run has the same value; addresses must be 0..n-1.
    task automatic check_run(input int idx, input string tag, input int n_exp,
                             input int data_exp, input int done_exp, input int done_cyc);
        int n;
        n = wr_addr_q[idx].size();
        check_eq({tag, " writes"}, n, n_exp);
        for (int k = 0; k < n && k < n_exp; k++) begin
            check_eq($sformatf("%s addr[%0d]", tag, k), wr_addr_q[idx][k], k);
            check_eq($sformatf("%s data[%0d]", tag, k), wr_data_q[idx][k], data_exp);
        end
        check_eq({tag, " done cycle"}, done_cyc, done_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int n_before;
        int d0;
        rst     = 1'b0;
        start_v = '0;
        for (int i = 0; i < 5; i++) begin
            bias_v[i]   = '0;
            done_cnt[i] = 0;
            for (int a = 0; a < 1024; a++) img_mem[i][a] = 8'd0;
            for (int a = 0; a < 16; a++)   w_mem[i][a]   = 8'd0;
        end
        for (int a = 0; a < 1024; a++) begin
            img_mem[0][a] = 8'd1;
            img_mem[1][a] = 8'd255;
            img_mem[2][a] = 8'd255;
        end
        for (int a = 0; a < 16; a++) begin
            w_mem[0][a] = 8'd1;
            w_mem[1][a] = 8'd127;
            w_mem[2][a] = 8'h80;
            w_mem[3][a] = 8'd5;
        end
        for (int a = 0; a < 15; a++) img_mem[4][a] = 8'(a);
        for (int a = 0; a < 4; a++)  w_mem[4][a] = 8'(a + 1);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("reset busy",     int'(busy_v[0]), 0);
        check_eq("reset done",     int'(done_v[0]), 0);
        check_eq("reset out_wen",  int'(wen_v[0]), 0);
        check_eq("reset out_addr", int'(oaddr_v[0]), 0);
        check_eq("reset out_data", int'(odata_v[0]), 0);
        check_eq("reset img_addr", int'(img_addr_v[0]), 0);
        check_eq("reset w_addr",   int'(w_addr_v[0]), 0);

        // T1: all-ones 4x4, K=2 -> nine results of 4, done at cycle 64
        run(0, 200, dc);
        check_run(0, "T1", 9, 4, 64, dc);

        // T2: saturation high, ReLU clamp, saturation low
        run(1, 300, dc);
        check_run(1, "T2 pos sat", 9, 127, 109, dc);
        for (int a = 0; a < 16; a++) w_mem[1][a] = 8'h80;
        run(1, 300, dc);
        check_run(1, "T2 relu", 9, 0, 109, dc);
        run(2, 300, dc);
        check_run(2, "T2 neg sat", 9, -128, 109, dc);

        // T3: SHIFT=8 rounding, acc driven by bias alone
        bias_v[3] = 16'd384;
        run(3, 100, dc);
        check_run(3, "T3 384", 4, 2, 29, dc);
        bias_v[3] = 16'd383;
        run(3, 100, dc);
        check_run(3, "T3 383", 4, 1, 29, dc);
        bias_v[3] = 16'hFF7F;
        run(3, 100, dc);
        check_run(3, "T3 -129", 4, -1, 29, dc);

        // T4: address walk on 5x3, K=2, weights 1..4 -> data 10a+41
        mac_img_q.delete();
        mac_w_q.delete();
        run(4, 200, dc);
        check_eq("T4 writes", wr_addr_q[4].size(), 8);
        for (int k = 0; k < 8 && k < wr_addr_q[4].size(); k++) begin
            check_eq($sformatf("T4 addr[%0d]", k), wr_addr_q[4][k], k);
            check_eq($sformatf("T4 data[%0d]", k), wr_data_q[4][k], 10 * ((k / 4) * 5 + k % 4) + 41);
        end
        check_eq("T4 done cycle", dc, 57);
        check_eq("T4 busy cycles", mac_img_q.size(), 57);
        for (int p = 0; p < 56 && p < mac_img_q.size(); p++) begin
            int n;
            int t;
            int a;
            n = p / 7;
            t = p % 7;
            a = (n / 4) * 5 + n % 4;
            if (t < 4) begin
                check_eq($sformatf("T4 img_addr out%0d tap%0d", n, t), mac_img_q[p], a + (t / 2) * 5 + t % 2);
                check_eq($sformatf("T4 w_addr out%0d tap%0d", n, t), mac_w_q[p], t);
            end
        end

        // T5: reset during MAC of the third output, then a clean full run
        wr_addr_q[0].delete();
        wr_data_q[0].delete();
        d0 = done_cnt[0];
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (15) @(negedge clk);
        n_before = wr_addr_q[0].size();
        rst = 1'b0;
        #1;
        check_eq("T5 writes before reset", n_before, 2);
        check_eq("T5 out_wen in reset",  int'(wen_v[0]), 0);
        check_eq("T5 busy in reset",     int'(busy_v[0]), 0);
        check_eq("T5 done in reset",     int'(done_v[0]), 0);
        check_eq("T5 out_addr in reset", int'(oaddr_v[0]), 0);
        check_eq("T5 out_data in reset", int'(odata_v[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("T5 no write after abort", wr_addr_q[0].size(), 2);
        check_eq("T5 no done after abort", done_cnt[0] - d0, 0);
        run(0, 200, dc);
        check_run(0, "T5 rerun", 9, 4, 64, dc);

        // T6: start pulses while busy and during DONE are ignored
        wr_addr_q[0].delete();
        wr_data_q[0].delete();
        d0 = done_cnt[0];
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int cyc = 1; cyc <= 160; cyc++) begin
            @(negedge clk);
            start_v[0] = (cyc == 10 || cyc == 40 || done_v[0] === 1'b1) ? 1'b1 : 1'b0;
        end
        start_v[0] = 1'b0;
        @(negedge clk);
        check_eq("T6 done count", done_cnt[0] - d0, 1);
        check_eq("T6 writes", wr_addr_q[0].size(), 9);
        check_eq("T6 idle at end", int'(busy_v[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
